// File: rtl/mac_issue_seq_if.sv
// Signal bundle for mac_issue_seq: job control, operand stream, MAC array side, result port.
// master = sequencer view, slave = surrounding logic (operand buffer, MAC array, post-processing).
interface mac_issue_seq_if #(
  parameter int MAX_MACS          = 64,
  parameter int DATA_WIDTH        = 8,
  parameter int MAX_GROUPS        = 8,
  parameter int MAC_BIT_PER_GROUP = 6,
  parameter int LEN_W             = 12,
  parameter int ACC_WIDTH         = 32
);
  localparam int G_W = $clog2(MAX_GROUPS + 1);

  logic                                 start;
  logic [G_W-1:0]                       cfg_groups;
  logic [LEN_W-1:0]                     cfg_len;
  logic                                 cfg_err;
  logic                                 busy;
  logic                                 s_valid;
  logic                                 s_ready;
  logic [DATA_WIDTH-1:0]                s_act;
  logic [DATA_WIDTH-1:0]                s_wgt;
  logic [G_W-1:0]                       mac_num_groups;
  logic [MAX_GROUPS*MAC_BIT_PER_GROUP-1:0] mac_num_macs;
  logic                                 mac_valid_in;
  logic [MAX_MACS*DATA_WIDTH-1:0]       mac_data;
  logic [MAX_MACS*DATA_WIDTH-1:0]       mac_weight;
  logic [MAX_GROUPS*4*DATA_WIDTH-1:0]   mac_out_i;
  logic                                 mac_valid_out_i;
  logic                                 res_valid;
  logic                                 res_ready;
  logic [MAX_GROUPS*ACC_WIDTH-1:0]      res_data;

  modport master (
    input  start, cfg_groups, cfg_len, s_valid, s_act, s_wgt, mac_out_i, mac_valid_out_i, res_ready,
    output cfg_err, busy, s_ready, mac_num_groups, mac_num_macs, mac_valid_in, mac_data, mac_weight,
           res_valid, res_data
  );

  modport slave (
    output start, cfg_groups, cfg_len, s_valid, s_act, s_wgt, mac_out_i, mac_valid_out_i, res_ready,
    input  cfg_err, busy, s_ready, mac_num_groups, mac_num_macs, mac_valid_in, mac_data, mac_weight,
           res_valid, res_data
  );
endinterface

// File: rtl/mac_issue_seq.sv
// Issue sequencer for the grouped MAC array: packs a serial operand stream into passes and
// accumulates per-group partial sums. Define ACC_SAT_EN for saturating accumulation (default wraps).
module mac_issue_seq #(
  parameter int MAX_MACS          = 64,
  parameter int DATA_WIDTH        = 8,
  parameter int MAX_GROUPS        = 8,
  parameter int MAC_BIT_PER_GROUP = 6,
  parameter int LEN_W             = 12,
  parameter int ACC_WIDTH         = 32
) (
  input logic             clk,
  input logic             rst,
  mac_issue_seq_if.master bus
);
  localparam int G_W     = $clog2(MAX_GROUPS + 1);
  localparam int LANE_W  = $clog2(MAX_MACS);
  localparam int PS_W    = 4 * DATA_WIDTH;
  localparam int SUM_W   = ((ACC_WIDTH > PS_W) ? ACC_WIDTH : PS_W) + 1;
  localparam int CNT_W   = LEN_W + 1;
  localparam int LPG_MAX = 2 ** (MAC_BIT_PER_GROUP - 1);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ISSUE, S_WAIT, S_OUT} state_t;

  state_t                 state, state_n;
  logic [G_W-1:0]         groups_q, grp_cnt, ng_q;
  logic [CNT_W-1:0]       len_q, lpg_q, pass_base, elem_cnt;
  logic [LANE_W-1:0]      lane_ptr;
  logic [DATA_WIDTH-1:0]  stg_data [MAX_MACS];
  logic [DATA_WIDTH-1:0]  stg_wgt  [MAX_MACS];
  logic [DATA_WIDTH-1:0]  stg_data_n [MAX_MACS];
  logic [DATA_WIDTH-1:0]  stg_wgt_n  [MAX_MACS];
  logic [MAX_MACS*DATA_WIDTH-1:0] data_q, wgt_q, data_pack, wgt_pack;
  logic [MAX_GROUPS*MAC_BIT_PER_GROUP-1:0] nm_q, nm_n;
  logic signed [ACC_WIDTH-1:0] acc [MAX_GROUPS];
  logic                   cfg_err_q;

  logic                   cfg_bad, beat, elem_last, grp_last, pass_last_beat, more_passes;
  logic [CNT_W-1:0]       remain, n_cur, next_base;

  // Lanes per group: largest power of two that fits the array, capped by the num_macs field width.
  function automatic logic [CNT_W-1:0] lpg_for(input logic [G_W-1:0] g);
    int q, p;
    p = 1;
    if (g != '0) begin
      q = MAX_MACS / int'(g);
      for (int i = 0; i < 31; i++)
        if ((1 << i) <= q) p = 1 << i;
    end
    if (p > LPG_MAX) p = LPG_MAX;
    return CNT_W'(p);
  endfunction

`ifdef ACC_SAT_EN
  localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
`endif

  function automatic logic signed [ACC_WIDTH-1:0] acc_add(input logic signed [ACC_WIDTH-1:0] a,
                                                          input logic [PS_W-1:0] b);
    logic signed [SUM_W-1:0] s;
    s = {{(SUM_W-ACC_WIDTH){a[ACC_WIDTH-1]}}, a} + {{(SUM_W-PS_W){b[PS_W-1]}}, b};
`ifdef ACC_SAT_EN
    if (s > ACC_MAX) s = ACC_MAX;
    else if (s < ACC_MIN) s = ACC_MIN;
`endif
    return s[ACC_WIDTH-1:0];
  endfunction

  assign cfg_bad        = (bus.cfg_groups == '0) || (bus.cfg_groups > G_W'(MAX_GROUPS)) ||
                          (bus.cfg_len == '0);
  assign remain         = len_q - pass_base;
  assign n_cur          = (remain < lpg_q) ? remain : lpg_q;
  assign beat           = (state == S_FILL) && bus.s_valid;
  assign elem_last      = (elem_cnt == n_cur - CNT_W'(1));
  assign grp_last       = (grp_cnt == groups_q - G_W'(1));
  assign pass_last_beat = beat && elem_last && grp_last;
  assign next_base      = pass_base + lpg_q;
  assign more_passes    = (next_base < len_q);

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    state_n          = state;
    bus.s_ready      = 1'b0;
    bus.mac_valid_in = 1'b0;
    bus.res_valid    = 1'b0;
    bus.busy         = (state != S_IDLE);
    unique case (state)
      S_IDLE:  if (bus.start && !cfg_bad) state_n = S_FILL;
      S_FILL: begin
        bus.s_ready = 1'b1;
        if (pass_last_beat) state_n = S_ISSUE;
      end
      S_ISSUE: begin
        bus.mac_valid_in = 1'b1;
        state_n          = S_WAIT;
      end
      S_WAIT:  if (bus.mac_valid_out_i) state_n = more_passes ? S_FILL : S_OUT;
      S_OUT: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Staging image including the current beat, so the final beat of a pass lands in the issued image.
  always_comb begin
    stg_data_n = stg_data;
    stg_wgt_n  = stg_wgt;
    if (beat) begin
      stg_data_n[lane_ptr] = bus.s_act;
      stg_wgt_n[lane_ptr]  = bus.s_wgt;
    end
    data_pack = '0;
    wgt_pack  = '0;
    for (int l = 0; l < MAX_MACS; l++) begin
      data_pack[l*DATA_WIDTH +: DATA_WIDTH] = stg_data_n[l];
      wgt_pack[l*DATA_WIDTH +: DATA_WIDTH]  = stg_wgt_n[l];
    end
    nm_n = '0;
    for (int g = 0; g < MAX_GROUPS; g++)
      if (G_W'(g) < groups_q) nm_n[g*MAC_BIT_PER_GROUP +: MAC_BIT_PER_GROUP] = n_cur[MAC_BIT_PER_GROUP-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only; later assignments in this block win.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      groups_q  <= '0;
      grp_cnt   <= '0;
      ng_q      <= '0;
      len_q     <= '0;
      lpg_q     <= '0;
      pass_base <= '0;
      elem_cnt  <= '0;
      lane_ptr  <= '0;
      data_q    <= '0;
      wgt_q     <= '0;
      nm_q      <= '0;
      cfg_err_q <= 1'b0;
      // NOTE: the staging lanes are cleared on reset because unused lanes must issue as zero.
      for (int l = 0; l < MAX_MACS; l++) begin
        stg_data[l] <= '0;
        stg_wgt[l]  <= '0;
      end
      for (int g = 0; g < MAX_GROUPS; g++) acc[g] <= '0;
    end else begin
      state     <= state_n;
      cfg_err_q <= (state == S_IDLE) && bus.start && cfg_bad;
      stg_data  <= stg_data_n;
      stg_wgt   <= stg_wgt_n;
      unique case (state)
        S_IDLE: if (bus.start && !cfg_bad) begin
          groups_q  <= bus.cfg_groups;
          len_q     <= {1'b0, bus.cfg_len};
          lpg_q     <= lpg_for(bus.cfg_groups);
          pass_base <= '0;
          elem_cnt  <= '0;
          grp_cnt   <= '0;
          lane_ptr  <= '0;
          for (int g = 0; g < MAX_GROUPS; g++) acc[g] <= '0;
        end
        S_FILL: if (beat) begin
          lane_ptr <= pass_last_beat ? '0 : lane_ptr + LANE_W'(1);
          if (!elem_last) begin
            elem_cnt <= elem_cnt + CNT_W'(1);
          end else begin
            elem_cnt <= '0;
            grp_cnt  <= grp_last ? '0 : grp_cnt + G_W'(1);
          end
          if (pass_last_beat) begin
            data_q <= data_pack;
            wgt_q  <= wgt_pack;
            nm_q   <= nm_n;
            ng_q   <= groups_q;
          end
        end
        // The issued image is captured, so staging restarts from zero for the next pass.
        S_ISSUE: for (int l = 0; l < MAX_MACS; l++) begin
          stg_data[l] <= '0;
          stg_wgt[l]  <= '0;
        end
        S_WAIT: if (bus.mac_valid_out_i) begin
          pass_base <= next_base;
          for (int g = 0; g < MAX_GROUPS; g++)
            if (G_W'(g) < groups_q) acc[g] <= acc_add(acc[g], bus.mac_out_i[g*PS_W +: PS_W]);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int g = 0; g < MAX_GROUPS; g++) bus.res_data[g*ACC_WIDTH +: ACC_WIDTH] = acc[g];
  end

  assign bus.cfg_err        = cfg_err_q;
  assign bus.mac_data       = data_q;
  assign bus.mac_weight     = wgt_q;
  assign bus.mac_num_macs   = nm_q;
  assign bus.mac_num_groups = ng_q;
endmodule

// File: doc/mac_issue_seq.md
Name: mac_issue_seq

Overview:
- Initiator-side sequencer for the grouped MAC array. Drives its data/weight/num_groups/num_macs/valid_in interface and consumes its per-group partial sums.
- Takes a serial operand stream for up to MAX_GROUPS independent dot products of equal length cfg_len.
- Packs operands into MAC passes, issues each pass and accumulates the returned partial sums across passes.
- Presents the final per-group results on a valid/ready port; sits between the operand buffer and the post-processing stage.

Parameters:
- MAX_MACS, 64, total MAC lanes.
- DATA_WIDTH, 8, signed operand width.
- MAX_GROUPS, 8, max concurrent groups.
- MAC_BIT_PER_GROUP, 6, width of each per-group lane-count field.
- LEN_W, 12, width of cfg_len.
- ACC_WIDTH, 32, signed result width per group.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  begin job; config sampled this cycle
- cfg_groups  in  $clog2(MAX_GROUPS+1)  groups, 1..MAX_GROUPS
- cfg_len  in  LEN_W  dot-product length per group, >=1
- cfg_err  out  1  one-cycle pulse on rejected start
- busy  out  1  high from accepted start until result handshake
- s_valid  in  1  operand beat valid
- s_ready  out  1  operand beat accepted when s_valid&s_ready
- s_act  in  DATA_WIDTH  signed activation
- s_wgt  in  DATA_WIDTH  signed weight
- mac_num_groups  out  $clog2(MAX_GROUPS+1)  to MAC num_groups
- mac_num_macs  out  MAX_GROUPS*MAC_BIT_PER_GROUP  to MAC num_macs_i
- mac_valid_in  out  1  to MAC valid_in
- mac_data  out  MAX_MACS*DATA_WIDTH  to MAC data
- mac_weight  out  MAX_MACS*DATA_WIDTH  to MAC weight
- mac_out_i  in  MAX_GROUPS*4*DATA_WIDTH  from MAC mac_out, signed per group
- mac_valid_out_i  in  1  from MAC valid_out
- res_valid  out  1  result valid
- res_ready  in  1  result accepted
- res_data  out  MAX_GROUPS*ACC_WIDTH  group g at [g*ACC_WIDTH +: ACC_WIDTH]

Behaviour:
- Reset: all outputs 0, state IDLE, accumulators 0, staging registers 0.
- LPG (lanes per group) is fixed at start:
  - min(2^(MAC_BIT_PER_GROUP-1), largest power of two <= MAX_MACS/cfg_groups).
  - Defaults: groups 1-2 -> 32, 3-4 -> 16, 5-8 -> 8.
- Passes: P = ceil(cfg_len/LPG). Pass p, group g uses n = min(LPG, cfg_len - p*LPG) lanes.
- Stream order: pass-major, then group 0..G-1, then element p*LPG .. p*LPG+n-1. Only valid elements are sent; tail lanes get no beats.
- Lane packing is contiguous: group g starts at lane sum of n over groups < g. Unused lanes are driven 0. Unused groups' num_macs fields are 0.
- States:
  - IDLE: on start with valid config, latch config, clear accumulators, busy=1, go to FILL. With cfg_groups==0, cfg_groups>MAX_GROUPS or cfg_len==0, pulse cfg_err and stay IDLE.
  - FILL: s_ready=1; one beat per cycle written to the next lane. After the last beat of the pass, go to ISSUE.
  - ISSUE: mac_valid_in=1 for exactly one cycle. mac_data, mac_weight, mac_num_macs and mac_num_groups are stable that cycle and held until the next ISSUE. Go to WAIT.
  - WAIT: s_ready=0. On mac_valid_out_i (nominally 2 cycles after ISSUE; no timeout), acc[g] += sign-extended mac_out_i group g for each g < G. If passes remain go to FILL, else go to OUT.
  - OUT: res_valid=1 and res_data stable until res_ready. On the handshake, res_valid=0, busy=0, go to IDLE.
- Arithmetic:
  - Sum is formed at max(ACC_WIDTH, 4*DATA_WIDTH)+1 bits, then reduced to ACC_WIDTH.
  - Default reduction is wrap (low bits).
  - res_data groups >= G are 0.
- start is ignored while busy. s_valid outside FILL is not consumed. mac_valid_out_i outside WAIT is ignored.
- rst low mid-job: abort immediately to the reset state; the in-flight MAC return is discarded.
- Latency, single pass: last beat -> ISSUE next cycle -> accumulate on mac_valid_out_i -> res_valid the cycle after.

Optional Feature:
- ACC_SAT_EN defined: each accumulation saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
- ACC_SAT_EN undefined: two's-complement wrap.

Test Plan:
- groups=1, len=4, act={1,2,3,4}, wgt={1,1,1,1} -> one ISSUE; num_macs field0=4; res_data[0]=10.
- groups=2, len=40, all act=1, wgt=2 -> two passes with num_macs {32,32} then {8,8}; second pass uses lanes 0-7 and 8-15; res {80,80}.
- groups=3, len=5, act=-3, wgt=7 -> LPG=16, num_macs {5,5,5}, group starts at lanes 0/5/10; res {-105,-105,-105}.
- ACC_WIDTH=20, groups=1, len=64, act=wgt=-128:
  - wrap -> res 0.
  - with ACC_SAT_EN -> res 524287.
- Hold res_ready=0 for 5 cycles -> res_valid and res_data stable, s_ready=0; start pulsed meanwhile is ignored.
- start with cfg_groups=9 -> cfg_err one pulse, busy stays 0. Reset asserted during WAIT -> all outputs 0; next job computes correctly.
